microcode_pipeline: RTL
=======================

Name: microcode_pipeline

Overview:
Parametrised carrier for decoded microcode words through an N-stage in-order execution pipeline. Each stage register holds a valid bit, the microcode word and the destination register, and exposes them to that stage's datapath.
The block adds entry-side RAW hazard interlock using the word's dependency-check and reg-write bits, global hold, partial flush and a retire counter.
It sits between the decoder and the execution datapath, replacing hand-wired per-stage microcode registers.

Parameters:
WIDTH, 25, microcode word width in bits
STAGES, 4, number of pipeline stages (2..8); stage 0 is the entry stage, stage STAGES-1 is writeback
REG_ADDR_W, 5, register index width
RS1_DEP_BIT, 0, bit index of "check rs1 dependency" in the microcode word
RS2_DEP_BIT, 1, bit index of "check rs2 dependency"
REG_WE_BIT, 22, bit index of "register write enable"
FLUSH_DEPTH, 2, number of youngest stages (0..FLUSH_DEPTH-1) killed by flush; 1..STAGES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoder presents a word
in_ready  out  1  word accepted at this edge when in_valid && in_ready
in_mc  in  WIDTH  microcode word
in_rs1  in  REG_ADDR_W  source register 1
in_rs2  in  REG_ADDR_W  source register 2
in_rd  in  REG_ADDR_W  destination register
hold_i  in  1  freeze pipeline (e.g. memory wait)
flush_i  in  1  kill the young stages (taken branch/jump)
stage_valid  out  STAGES  per-stage valid, bit s = stage s
stage_mc  out  STAGES*WIDTH  per-stage word, slice s = stage s
stage_rd  out  STAGES*REG_ADDR_W  per-stage destination
hazard  out  1  entry blocked by RAW dependency (combinational)
retire_count  out  32  instructions retired from the last stage

Behaviour:
- Clocking and reset: one clock domain, registered on the rising edge of clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all stage_valid=0, stage_mc=0, stage_rd=0, retire_count=0.
- Reset mid-operation clears all stages immediately. No in-flight word survives and none is counted as retired.
- Hazard definition:
  - A stage s is a producer when stage_valid[s] && stage_mc[s][REG_WE_BIT] && stage_rd[s]!=0.
  - hazard=1 when in_valid and either (in_mc[RS1_DEP_BIT] && in_rs1!=0 && in_rs1 equals the stage_rd of any producer) or the same check holds for RS2.
  - Register 0 never causes a hazard.
- Ready: in_ready = !hazard && !hold_i && !flush_i (all combinational).
- Advance, normal case (no hold, no flush), at each edge:
  - stage s+1 <= stage s;
  - stage 0 <= {1, in_mc, in_rd} if the word is accepted, else a bubble (valid=0, mc=0, rd=0).
  - Latency: an accepted word appears in stage 0 one cycle after acceptance and in stage STAGES-1 after STAGES cycles, absent holds.
- Hold (hold_i=1, flush_i=0): every stage keeps its contents and nothing is accepted.
- Flush (flush_i=1):
  - Stages 0..FLUSH_DEPTH-1 become bubbles at the next edge; the input word is not accepted.
  - Stages FLUSH_DEPTH..STAGES-1 hold if hold_i, otherwise they shift normally. Stage FLUSH_DEPTH receives a bubble because its predecessor was killed.
  - FLUSH_DEPTH=STAGES clears everything.
- Retire: when stage_valid[STAGES-1]=1 and hold_i=0 at an edge, retire_count increments by 1, wrapping from 0xFFFFFFFF to 0. Flush does not inhibit retirement of the last stage when FLUSH_DEPTH<STAGES.
- A hazard clears by itself: the producer drains out of the last stage and entry resumes the cycle after it leaves. There is no deadlock because hold_i alone freezes drain.
- All outputs other than hazard and in_ready are registered.

Test Plan:
- Reset, then 4 back-to-back independent words with REG_WE=1, rd=1..4: stage_valid walks 0001→0011→0111→1111; after 8 edges retire_count=4 and all stages are invalid.
- RAW stall: accept a word writing rd=5, then present a word with RS1_DEP=1, rs1=5. Required: hazard=1 and in_ready=0 for 4 cycles (STAGES=4), accepted on the 5th. The same test with rs1=0 or RS1_DEP=0 is accepted immediately.
- Hold: pipeline full (words A,B,C,D) with hold_i=1 for 3 cycles: stage contents unchanged, retire_count unchanged, in_ready=0. On release, D retires on the next edge.
- Flush: pipeline full with A in stage 0 and B in stage 1, flush_i=1 for one cycle with in_valid=1. Required next cycle: stages 0,1 and 2 invalid, stage 3 holds the old stage-2 word, retire_count +1, and the input word is not accepted.
- Flush with hold together: FLUSH_DEPTH=2 on a full pipe. Stages 0–1 are cleared, stages 2–3 unchanged, retire_count unchanged.
- Counter wrap and async reset: force retire_count to 0xFFFFFFFF, then retire one word: count becomes 0. Assert rst_n low mid-clock: all stage_valid drop before the next edge.

Source files
------------

// File: rtl/microcode_pipeline.sv
// microcode_pipeline: in-order N-stage microcode carrier with RAW entry interlock, hold, partial flush and retire count
module microcode_pipeline #(
  parameter int WIDTH       = 25,
  parameter int STAGES      = 4,
  parameter int REG_ADDR_W  = 5,
  parameter int RS1_DEP_BIT = 0,
  parameter int RS2_DEP_BIT = 1,
  parameter int REG_WE_BIT  = 22,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_mc,
  input  logic [REG_ADDR_W-1:0]        in_rs1,
  input  logic [REG_ADDR_W-1:0]        in_rs2,
  input  logic [REG_ADDR_W-1:0]        in_rd,
  input  logic                         hold_i,
  input  logic                         flush_i,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_mc,
  output logic [STAGES*REG_ADDR_W-1:0] stage_rd,
  output logic                         hazard,
  output logic [31:0]                  retire_count
);
  logic [STAGES-1:0]     v_q;
  logic [WIDTH-1:0]      mc_q [STAGES];
  logic [REG_ADDR_W-1:0] rd_q [STAGES];
  logic                  p_v  [STAGES];
  logic [WIDTH-1:0]      p_mc [STAGES];
  logic [REG_ADDR_W-1:0] p_rd [STAGES];
  logic accept, retire;
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < STAGES; s++)
      if (in_valid && v_q[s] && mc_q[s][REG_WE_BIT] && rd_q[s] != '0 &&
          ((in_mc[RS1_DEP_BIT] && in_rs1 == rd_q[s]) || (in_mc[RS2_DEP_BIT] && in_rs2 == rd_q[s])))
        hazard = 1'b1;
  end
  assign in_ready = !hazard && !hold_i && !flush_i;
  assign accept   = in_valid && in_ready;
  // a full-depth flush empties the last stage too, so nothing retires
  assign retire   = v_q[STAGES-1] && !hold_i && !(flush_i && FLUSH_DEPTH >= STAGES);
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    if (g == 0) begin : g_in
      assign p_v[g]  = accept;
      assign p_mc[g] = accept ? in_mc : '0;
      assign p_rd[g] = accept ? in_rd : '0;
    end else begin : g_sh
      logic kill;
      assign kill    = flush_i && (g == FLUSH_DEPTH);
      assign p_v[g]  = !kill && v_q[g-1];
      assign p_mc[g] = kill ? '0 : mc_q[g-1];
      assign p_rd[g] = kill ? '0 : rd_q[g-1];
    end
    assign stage_valid[g]                         = v_q[g];
    assign stage_mc[g*WIDTH +: WIDTH]             = mc_q[g];
    assign stage_rd[g*REG_ADDR_W +: REG_ADDR_W]   = rd_q[g];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        mc_q[s] <= '0;
        rd_q[s] <= '0;
      end
      retire_count <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush_i && s < FLUSH_DEPTH) begin
          v_q[s]  <= 1'b0;
          mc_q[s] <= '0;
          rd_q[s] <= '0;
        end else if (!hold_i) begin
          v_q[s]  <= p_v[s];
          mc_q[s] <= p_mc[s];
          rd_q[s] <= p_rd[s];
        end
      end
      if (retire) retire_count <= retire_count + 32'd1;
    end
  end
endmodule
